// File: rtl/seq_adder_acc_pkg.sv
// Shared types and default sizes for the sequential adder/accumulator.
// Configuration macro: SEQ_ADDER_ACC_SAT_EN (saturating accumulate).
package seq_adder_acc_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_ACC_W = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

endpackage

// File: rtl/acc_add_unit.sv
// Combinational y + (a + b) with overflow detect.
// Configuration macro: SEQ_ADDER_ACC_SAT_EN clamps instead of wrapping.
module acc_add_unit
  import seq_adder_acc_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] y,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [W:0]     ab;
  logic [ACC_W:0] full;

  always_comb begin
    ab   = {1'b0, a} + {1'b0, b};
    full = {1'b0, y} + {{(ACC_W-W){1'b0}}, ab};
    ovf  = full[ACC_W];
`ifdef SEQ_ADDER_ACC_SAT_EN
    sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    sum  = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/seq_adder_acc.sv
// Sequential single-add / multi-beat accumulator with valid/ready ends.
// Configuration macro: SEQ_ADDER_ACC_SAT_EN (saturating accumulate).
module seq_adder_acc
  import seq_adder_acc_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             mode,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] y,
  output logic [CNT_W-1:0] beats,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] BEAT_ONE = CNT_W'(1);

  state_e           state;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             accept;
  logic [CNT_W-1:0] beats_inc;

  // A new result starts from zero; only ACCUM folds in the held y.
  always_comb begin
    base      = (state == ACCUM) ? y : '0;
    accept    = in_valid && in_ready;
    beats_inc = (&beats) ? beats : beats + BEAT_ONE;
  end

  acc_add_unit #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_add (
    .y   (base),
    .a   (a),
    .b   (b),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= '0;
      beats     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            y     <= sum;
            beats <= BEAT_ONE;
            ovf   <= add_ovf;
            if (mode_e'(mode) == MODE_ADD || last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            y     <= sum;
            beats <= beats_inc;
            ovf   <= ovf | add_ovf;
            if (last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder_acc.sv
// Scoreboard bench for seq_adder_acc: driver pushes expected results,
// a negedge monitor pops and compares each consumed result.
module tb_seq_adder_acc;

  localparam int W     = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;
  localparam longint YMAX = (longint'(1) << ACC_W) - 1;
  localparam longint BMAX = (longint'(1) << CNT_W) - 1;

  typedef struct {
    longint y;
    longint beats;
    bit     ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             mode;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] y;
  logic [CNT_W-1:0] beats;
  logic             ovf;

  int     n_vec = 0;
  int     n_bad = 0;
  int     n_push = 0;
  int     n_pop = 0;
  exp_t   q[$];
  bit     in_seq = 1'b0;
  longint acc_sum = 0;
  longint acc_n = 0;
  time    acc_t = 0;
  bit     sat_en;

  seq_adder_acc #(
    .W     (W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .beats     (beats),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: total of all operand sums, then wrap or clamp at the end.
  task automatic model_accept(input int ta, input int tb_, input bit tm,
                              input bit tl);
    exp_t e;
    bit   fin;
    if (!in_seq) begin
      acc_sum = 0;
      acc_n   = 0;
    end
    acc_sum += ta + tb_;
    acc_n++;
    fin = in_seq ? tl : (tm == 1'b0 || tl);
    if (fin) begin
      e.ovf   = (acc_sum > YMAX);
      e.y     = sat_en ? ((acc_sum > YMAX) ? YMAX : acc_sum)
                       : (acc_sum % (YMAX + 1));
      e.beats = (acc_n > BMAX) ? BMAX : acc_n;
      q.push_back(e);
      n_push++;
      in_seq = 1'b0;
    end else begin
      in_seq = 1'b1;
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic beat(input int ta, input int tb_, input bit tm,
                      input bit tl);
    bit ok;
    a        = W'(ta);
    b        = W'(tb_);
    mode     = tm;
    last     = tl;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    acc_t = $time;
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1");
    end else begin
      model_accept(ta, tb_, tm, tl);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_pop++;
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result: got y=%0d, expected none", y);
        end else begin
          e = q.pop_front();
          check("y", longint'(y), e.y);
          check("beats", longint'(beats), e.beats);
          check("ovf", longint'(ovf), longint'(e.ovf));
        end
      end
    end
  end

  initial begin : stim
    time t_prev;
`ifdef SEQ_ADDER_ACC_SAT_EN
    sat_en = 1'b1;
`else
    sat_en = 1'b0;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = 1'b0;
    last      = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_y", longint'(y), 0);
    check("rst_beats", longint'(beats), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", longint'(in_ready), 1);

    // Single add 5+5
    beat(5, 5, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Accumulate (3,6),(1,4),(12,9,last) -> 35
    beat(3, 6, 1'b1, 1'b0);
    beat(1, 4, 1'b0, 1'b0);
    beat(12, 9, 1'b1, 1'b1);
    @(posedge clk); #1;

    // 20 beats of (15,15): wraps to 88 or clamps to 255
    for (int i = 0; i < 20; i++) beat(15, 15, 1'b1, i == 19);
    @(posedge clk); #1;

    // Stall the result; in_valid during DONE must be ignored
    out_ready = 1'b0;
    beat(5, 5, 1'b0, 1'b0);
    a = 4'd7; b = 4'd7; mode = 1'b0; last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_y", longint'(y), 10);
      check("hold_in_ready", longint'(in_ready), 0);
      check("hold_out_valid", longint'(out_valid), 1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", longint'(in_ready), 1);
    check("release_out_valid", longint'(out_valid), 0);

    // Reset in the middle of an accumulation discards it
    beat(9, 9, 1'b1, 1'b0);
    beat(8, 8, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_y", longint'(y), 0);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    in_seq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1, 1, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Random single adds at full rate: one result per two cycles
    t_prev = 0;
    for (int i = 0; i < 20; i++) begin
      beat($urandom_range(0, 15), $urandom_range(0, 15), 1'b0,
           1'($urandom_range(0, 1)));
      if (i > 0) check("throughput_dt", longint'(acc_t - t_prev), 20);
      t_prev = acc_t;
    end
    @(posedge clk); #1;

    // Random accumulate sequences, mode ignored after the first beat
    for (int s = 0; s < 10; s++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++)
        beat($urandom_range(0, 15), $urandom_range(0, 15),
             (k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), k == len - 1);
      @(posedge clk); #1;
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", longint'(q.size()), 0);
    check("results_consumed", longint'(n_pop), longint'(n_push));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
